// File: rtl/xmpl_fft_frm.sv
// Ping-pong framer that reorders a natural-order sample stream into per-frame
// bit-reversed order for a radix-2 FFT core; two banks let ingest and drain overlap.
module xmpl_fft_frm #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sof_o,
  output logic              out_eof_o,
  input  logic              out_ready_i,
  output logic [7:0]        frm_cnt_o,
  output logic              busy_o
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  logic [DATA_W-1:0] mem_q [2][N];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]        frm_cnt_q, frm_cnt_d;
  logic              wr_fire, rd_fire;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready_o  = en_i & ~full_q[wr_bank_q] & ~clr_i;
  assign out_valid_o = full_q[rd_bank_q];
  assign out_data_o  = mem_q[rd_bank_q][rd_cnt_q];
  assign out_sof_o   = out_valid_o & (rd_cnt_q == '0);
  assign out_eof_o   = out_valid_o & (rd_cnt_q == CNT_LAST);
  assign frm_cnt_o   = frm_cnt_q;
  assign busy_o      = full_q[0] | full_q[1] | (wr_cnt_q != '0);

  assign wr_fire = in_valid_i & in_ready_o;
  assign rd_fire = out_valid_o & out_ready_i & ~clr_i;

  // A completing write and a completing read always target different banks,
  // so their full-flag updates never collide.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == CNT_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == CNT_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        frm_cnt_d         = frm_cnt_q + 8'd1;
      end
    end
    if (clr_i) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      frm_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      frm_cnt_q <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  // Sample storage is not reset; the full flags alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_fire && !reset_i) mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data_i;
  end

endmodule

// File: tb/tb_xmpl_fft_frm.sv
// Scoreboard bench for xmpl_fft_frm: a frame model pushes bit-reversed expectations
// on each completed input frame and the output monitor pops and compares them.
module tb_xmpl_fft_frm;

  localparam int DATA_W = 16;
  localparam int N      = 16;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              en_i = 1'b1;
  logic              clr_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_sof_o;
  logic              out_eof_o;
  logic              out_ready_i = 1'b1;
  logic [7:0]        frm_cnt_o;
  logic              busy_o;

  int errors = 0;
  int checks = 0;

  int sb[$];
  int out_log[$];
  int frame[N];
  int fill = 0;
  int opos = 0;
  int exp_frm = 0;
  bit hold_v = 1'b0;
  logic [DATA_W-1:0] hold_d;
  logic hold_s, hold_e;

  always #5 clk_i = ~clk_i;

  xmpl_fft_frm #(.DATA_W(DATA_W), .LOG2N(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .clr_i(clr_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_sof_o(out_sof_o),
    .out_eof_o(out_eof_o), .out_ready_i(out_ready_i), .frm_cnt_o(frm_cnt_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int bitrev4(input int a);
    int r = 0;
    for (int i = 0; i < 4; i++) if (a[i]) r |= (1 << (3 - i));
    return r;
  endfunction

  // Monitor and reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk_i) begin
    if (reset_i || clr_i) begin
      if (clr_i && !reset_i) chk("in_ready_clr", 32'(in_ready_o), 32'd0);
      sb.delete();
      fill = 0; opos = 0; exp_frm = 0; hold_v = 1'b0;
    end else begin
      chk("out_valid", 32'(out_valid_o), 32'(sb.size() != 0));
      chk("busy", 32'(busy_o), 32'((sb.size() != 0) || (fill != 0)));
      chk("in_ready", 32'(in_ready_o), 32'(en_i && (sb.size() <= N)));
      if (hold_v && out_valid_o) begin
        chk("hold_data", 32'(out_data_o), 32'(hold_d));
        chk("hold_sof", 32'(out_sof_o), 32'(hold_s));
        chk("hold_eof", 32'(out_eof_o), 32'(hold_e));
      end
      hold_v = 1'b0;
      if (out_valid_o) begin
        if (out_ready_i) begin
          chk("frm_cnt", 32'(frm_cnt_o), 32'(exp_frm));
          if (sb.size() == 0) chk("sb_empty_at_out", 32'(sb.size()), 32'd1);
          else chk("out_data", 32'(out_data_o), 32'(sb.pop_front()));
          out_log.push_back(int'(out_data_o));
          chk("sof", 32'(out_sof_o), 32'(opos == 0));
          chk("eof", 32'(out_eof_o), 32'(opos == N - 1));
          opos++;
          if (opos == N) begin
            opos = 0;
            exp_frm = (exp_frm + 1) % 256;
          end
        end else begin
          hold_v = 1'b1;
          hold_d = out_data_o; hold_s = out_sof_o; hold_e = out_eof_o;
        end
      end
      if (in_valid_i && in_ready_o) begin
        frame[fill] = int'(in_data_i);
        fill++;
        if (fill == N) begin
          for (int k = 0; k < N; k++) sb.push_back(frame[bitrev4(k)]);
          fill = 0;
        end
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic send(input int n, input int base);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      in_valid_i = 1'b1;
      in_data_i  = DATA_W'(base + i);
      @(negedge clk_i);
      if (in_ready_o) i++;
      @(posedge clk_i); #1;
      guard++;
    end
    in_valid_i = 1'b0;
    if (i < n) chk("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    cycles(1);
    clr_i = 1'b0;
    out_log.delete();
  endtask

  int exp1[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  initial begin
    cycles(3);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_frm_cnt", 32'(frm_cnt_o), 32'd0);
    reset_i = 1'b0;
    cycles(1);

    // Single frame, explicit bit-reversed order
    send(16, 0);
    cycles(20);
    chk("t1_frm_cnt", 32'(frm_cnt_o), 32'd1);
    chk("t1_count", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      chk("t1_order", 32'(out_log[i]), 32'(exp1[i]));

    // Continuous stream of three frames
    pulse_clr();
    send(48, 100);
    cycles(20);
    chk("t2_frm_cnt", 32'(frm_cnt_o), 32'd3);
    chk("t2_count", 32'(out_log.size()), 32'd48);

    // Backpressure until both banks fill
    pulse_clr();
    out_ready_i = 1'b0;
    fork
      send(40, 200);
      begin
        cycles(60);
        chk("t3_in_ready_low", 32'(in_ready_o), 32'd0);
        chk("t3_busy", 32'(busy_o), 32'd1);
        out_ready_i = 1'b1;
      end
    join
    cycles(30);
    chk("t3_frm_cnt", 32'(frm_cnt_o), 32'd2);
    chk("t3_busy_partial", 32'(busy_o), 32'd1);
    send(8, 240);
    cycles(20);
    chk("t3_frm_cnt_final", 32'(frm_cnt_o), 32'd3);
    chk("t3_busy_idle", 32'(busy_o), 32'd0);

    // Random output stalls
    pulse_clr();
    fork
      send(64, 300);
      repeat (150) begin
        out_ready_i = 1'($urandom_range(0, 1));
        cycles(1);
      end
    join
    out_ready_i = 1'b1;
    cycles(40);
    chk("t4_frm_cnt", 32'(frm_cnt_o), 32'd4);
    chk("t4_count", 32'(out_log.size()), 32'd64);

    // Ingest paused by en_i mid-frame
    pulse_clr();
    send(5, 400);
    en_i = 1'b0;
    in_valid_i = 1'b1;
    in_data_i = 16'hDEAD;
    cycles(10);
    chk("t5_busy_paused", 32'(busy_o), 32'd1);
    en_i = 1'b1;
    send(11, 405);
    cycles(20);
    chk("t5_frm_cnt", 32'(frm_cnt_o), 32'd1);
    chk("t5_count", 32'(out_log.size()), 32'd16);

    // reset_i, then clr_i, with a full frame pending and a partial one in progress
    for (int mode = 0; mode < 2; mode++) begin
      pulse_clr();
      out_ready_i = 1'b0;
      send(16, 500);
      send(7, 516);
      if (mode == 0) reset_i = 1'b1; else clr_i = 1'b1;
      cycles(1);
      reset_i = 1'b0;
      clr_i = 1'b0;
      chk("t6_out_valid", 32'(out_valid_o), 32'd0);
      chk("t6_frm_cnt", 32'(frm_cnt_o), 32'd0);
      chk("t6_busy", 32'(busy_o), 32'd0);
      out_ready_i = 1'b1;
      cycles(5);
      chk("t6_no_output", 32'(out_valid_o), 32'd0);
      send(16, 600);
      cycles(20);
      chk("t6_frm_cnt_after", 32'(frm_cnt_o), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xmpl_fft_frm.md
XMPL_FFT_FRM -- requirements
Module: xmpl_fft_frm

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the sample width in bits.
REQ-002 Parameter LOG2N, default 4, SHALL set the frame length N = 2^LOG2N samples, legal range 2..8.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-high.
REQ-005 en_i  input  1  ingest enable; low blocks new samples.
REQ-006 clr_i  input  1  synchronous flush of all frames and counters.
REQ-007 in_valid_i  input  1  input sample valid.
REQ-008 in_data_i  input  DATA_W  input sample, natural time order.
REQ-009 in_ready_o  output  1  block accepts the sample this cycle.
REQ-010 out_valid_o  output  1  output sample valid, toward the FFT core.
REQ-011 out_data_o  output  DATA_W  output sample, bit-reversed order.
REQ-012 out_sof_o  output  1  first sample of a frame.
REQ-013 out_eof_o  output  1  last sample of a frame.
REQ-014 out_ready_i  input  1  FFT core accepts the output sample.
REQ-015 frm_cnt_o  output  8  count of fully delivered frames, wraps 255->0.
REQ-016 busy_o  output  1  at least one bank holds data or is partially filled.

Function
REQ-017 Storage SHALL be two banks of N x DATA_W flops (ping-pong), with per-bank full flag, write bank pointer wr_bank, read bank pointer rd_bank, write count wr_cnt, and read count rd_cnt (each count LOG2N bits).
REQ-018 in_ready_o SHALL equal en_i AND NOT full[wr_bank] AND NOT clr_i, combinationally.
REQ-019 On in_valid_i AND in_ready_o, in_data_i SHALL be written to bank wr_bank at address bitrev(wr_cnt), and wr_cnt SHALL increment.
REQ-020 A write with wr_cnt = N-1 SHALL set full[wr_bank], toggle wr_bank and wrap wr_cnt to 0 in the same edge.
REQ-021 out_valid_o SHALL equal full[rd_bank]; out_data_o SHALL equal bank rd_bank at address rd_cnt (combinational read, no added pipeline).
REQ-022 out_sof_o SHALL equal out_valid_o AND rd_cnt = 0; out_eof_o SHALL equal out_valid_o AND rd_cnt = N-1.
REQ-023 On out_valid_o AND out_ready_i, rd_cnt SHALL increment; at rd_cnt = N-1 it SHALL wrap to 0, clear full[rd_bank], toggle rd_bank and increment frm_cnt_o.
REQ-024 Latency: out_valid_o SHALL assert on the cycle after the edge that accepts the Nth sample of a frame, provided the other bank is not being drained.
REQ-025 Ingest into one bank and drain from the other SHALL proceed in the same cycle; sustained throughput SHALL be 1 sample/cycle with out_ready_i held high.
REQ-026 A frame-completing write and a frame-completing read in the same cycle SHALL both take effect (different banks by construction).
REQ-027 When both banks are full, in_ready_o SHALL be low until a frame is drained; no sample SHALL be dropped or overwritten.
REQ-028 out_data_o, out_sof_o and out_eof_o SHALL hold stable while out_valid_o is high and out_ready_i is low.
REQ-029 en_i low SHALL NOT stall draining; a partially filled bank SHALL keep its contents and wr_cnt until en_i returns high.
REQ-030 busy_o SHALL equal full[0] OR full[1] OR wr_cnt != 0.
REQ-031 clr_i high SHALL, at the next edge, clear both full flags, wr_bank, rd_bank, wr_cnt, rd_cnt and frm_cnt_o; a handshake in that cycle SHALL be discarded.

Reset
REQ-032 With reset_i high at an edge, all state SHALL match the clr_i result: in_ready_o = en_i, out_valid_o = 0, out_sof_o = 0, out_eof_o = 0, frm_cnt_o = 0, busy_o = 0. Bank contents need not be reset.
REQ-033 Reset asserted mid-frame SHALL abandon the partial frame and any pending full frames, with no output after release until N new samples are accepted.

Verification
REQ-034 N=16, feed samples 0..15 with out_ready_i high -> one cycle after the 16th accept, output order is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with sof on 0, eof on 15, and frm_cnt_o = 1.
REQ-035 Continuous input 0..47 with out_ready_i high -> in_ready_o never deasserts; three bit-reversed frames are delivered back-to-back; frm_cnt_o = 3.
REQ-036 out_ready_i low, feed 40 samples -> in_ready_o drops after sample 31 and busy_o = 1; raise out_ready_i -> frames 0..15 then 16..31 are delivered, and samples 32..39 follow once a bank is freed.
REQ-037 Toggle out_ready_i randomly mid-frame -> out_data_o, out_sof_o and out_eof_o remain stable while stalled, and no sample is duplicated or lost.
REQ-038 en_i low after 5 samples for 10 cycles, then 11 more samples -> a single correct frame of 16 samples is delivered.
REQ-039 reset_i or clr_i pulse after 7 samples with one full frame pending -> out_valid_o = 0, frm_cnt_o = 0, busy_o = 0; the next 16 samples form a clean frame.
